// File: rtl/uart_fifo_peripheral.sv
// uart_fifo_peripheral: memory-mapped UART with TX/RX FIFOs, baud divisor and sticky status.
// Defining UART_PARITY_EN adds an even-parity bit on TX and a parity check on RX.
module uart_fifo_sync #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic do_push, do_pop;
    assign empty   = cnt == '0;
    assign full    = cnt == (AW+1)'(DEPTH);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rp];
    always_ff @(posedge clk) begin
        if (reset) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wp] <= din;
endmodule

module uart_fifo_peripheral #(
    parameter int FIFO_DEPTH  = 16,
    parameter int DATA_BITS   = 8,
    parameter int DEFAULT_DIV = 651
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    input  logic        rx
);
    localparam int BW = $clog2(DATA_BITS);
`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
    logic [1:0] reg_sel;
    logic wr_tx, rd_rx, wr_st, wr_div;
    logic [15:0] baud_div, div_eff;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic unused;
    assign reg_sel = addr[3:2];
    assign wr_tx   = cs && wr && reg_sel == 2'd0;
    assign rd_rx   = cs && !wr && reg_sel == 2'd1;
    assign wr_st   = cs && wr && reg_sel == 2'd2;
    assign wr_div  = cs && wr && reg_sel == 2'd3;
    assign div_eff = baud_div == 16'd0 ? 16'd1 : baud_div;
    assign unused  = &{1'b0, addr[31:4], addr[1:0], wdata[31:16]};

    state_t tx_state;
    logic [15:0] tx_cnt, tx_per;
    logic [3:0] tx_sub;
    logic [BW-1:0] tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic tx_tick, tx_bit_end, tx_pop, tx_busy;
    assign tx_tick    = tx_state != IDLE && tx_cnt >= tx_per - 16'd1;
    assign tx_bit_end = tx_tick && tx_sub == 4'd15;
    assign tx_pop     = !tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_bit_end));
    assign tx_busy    = tx_state != IDLE;

    uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_tx), .din(wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .head(tx_head), .empty(tx_empty), .full(tx_full)
    );

`ifdef UART_PARITY_EN
    logic tx_par;
    always_ff @(posedge clk) if (tx_pop) tx_par <= ^tx_head;
`endif
    // Baud counter and period are reloaded while idle, so leaving IDLE always starts a fresh bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= IDLE;
            tx       <= 1'b1;
            tx_cnt   <= '0;
            tx_per   <= 16'd1;
            tx_sub   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_state == IDLE) begin
            tx_cnt <= '0;
            tx_sub <= '0;
            tx_per <= div_eff;
            if (!tx_empty) begin
                tx_state <= START;
                tx       <= 1'b0;
                tx_shift <= tx_head;
            end
        end else begin
            tx_cnt <= tx_tick ? '0 : tx_cnt + 16'd1;
            if (tx_tick) tx_per <= div_eff;
            if (tx_tick) tx_sub <= tx_sub + 4'd1;
            if (tx_bit_end)
                case (tx_state)
                    START: begin
                        tx_state <= DATA;
                        tx       <= tx_shift[0];
                        tx_bit   <= '0;
                    end
                    DATA: begin
                        if (tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            tx_state <= PARITY;
                            tx       <= tx_par;
`else
                            tx_state <= STOP;
                            tx       <= 1'b1;
`endif
                        end else begin
                            tx_bit   <= tx_bit + BW'(1);
                            tx_shift <= tx_shift >> 1;
                            tx       <= tx_shift[1];
                        end
                    end
`ifdef UART_PARITY_EN
                    PARITY: begin
                        tx_state <= STOP;
                        tx       <= 1'b1;
                    end
`endif
                    STOP: begin
                        tx_state <= tx_empty ? IDLE : START;
                        tx       <= tx_empty;
                        if (!tx_empty) tx_shift <= tx_head;
                    end
                    default: ;
                endcase
        end
    end

    logic rx_m, rx_s, rx_prev;
    state_t rx_state;
    logic [15:0] rx_cnt, rx_per;
    logic [3:0] rx_sub;
    logic [BW-1:0] rx_bit;
    logic [DATA_BITS-1:0] rx_shift;
    logic rx_tick, rx_sample, stop_hi, stop_lo, par_ok, rx_push;
    logic rx_overrun, frame_err, parity_flag;
    assign rx_tick   = rx_state != IDLE && rx_cnt >= rx_per - 16'd1;
    assign rx_sample = rx_tick && (rx_state == START ? rx_sub == 4'd7 : rx_sub == 4'd15);
    assign stop_hi   = rx_sample && rx_state == STOP && rx_s;
    assign stop_lo   = rx_sample && rx_state == STOP && !rx_s;
    assign rx_push   = stop_hi && par_ok;

    uart_fifo_sync #(.DEPTH(FIFO_DEPTH), .W(DATA_BITS)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .din(rx_shift),
        .pop(rd_rx), .head(rx_head), .empty(rx_empty), .full(rx_full)
    );

    always_ff @(posedge clk) begin
        if (reset) {rx_m, rx_s, rx_prev} <= 3'b111;
        else {rx_m, rx_s, rx_prev} <= {rx, rx_m, rx_s};
    end

`ifdef UART_PARITY_EN
    logic rx_par, parity_err;
    assign par_ok      = !rx_par;
    assign parity_flag = parity_err;
    // rx_par accumulates data and parity bits; even parity leaves it clear.
    always_ff @(posedge clk) begin
        if (reset) rx_par <= 1'b0;
        else if (rx_state == IDLE) rx_par <= 1'b0;
        else if (rx_sample && (rx_state == DATA || rx_state == PARITY)) rx_par <= rx_par ^ rx_s;
    end
    always_ff @(posedge clk) begin
        if (reset) parity_err <= 1'b0;
        else parity_err <= (stop_hi && rx_par) || (parity_err && !(wr_st && wdata[7]));
    end
`else
    assign par_ok      = 1'b1;
    assign parity_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_per   <= 16'd1;
            rx_sub   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else if (rx_state == IDLE) begin
            rx_cnt <= '0;
            rx_sub <= '0;
            rx_per <= div_eff;
            if (rx_prev && !rx_s) rx_state <= START;
        end else begin
            rx_cnt <= rx_tick ? '0 : rx_cnt + 16'd1;
            if (rx_tick) rx_per <= div_eff;
            if (rx_tick) rx_sub <= rx_sample ? 4'd0 : rx_sub + 4'd1;
            if (rx_sample)
                case (rx_state)
                    START: begin
                        rx_state <= rx_s ? IDLE : DATA;
                        rx_bit   <= '0;
                    end
                    DATA: begin
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + BW'(1);
`ifdef UART_PARITY_EN
                        if (rx_bit == BW'(DATA_BITS - 1)) rx_state <= PARITY;
                    end
                    PARITY: rx_state <= STOP;
`else
                        if (rx_bit == BW'(DATA_BITS - 1)) rx_state <= STOP;
                    end
`endif
                    STOP: rx_state <= IDLE;
                    default: ;
                endcase
        end
    end

    // A sticky set in the same cycle as a software clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
            baud_div   <= 16'(DEFAULT_DIV);
        end else begin
            rx_overrun <= (stop_hi && par_ok && rx_full) || (rx_overrun && !(wr_st && wdata[4]));
            frame_err  <= stop_lo || (frame_err && !(wr_st && wdata[6]));
            if (wr_div) baud_div <= wdata[15:0];
        end
    end

    logic [7:0] status;
    assign status = {parity_flag, frame_err, tx_busy, rx_overrun, tx_full, tx_empty, rx_full, !rx_empty};
    assign rdata  = reg_sel == 2'd1 ? {{(32-DATA_BITS){1'b0}}, rx_empty ? {DATA_BITS{1'b0}} : rx_head} :
                    reg_sel == 2'd2 ? {24'h0, status} :
                    reg_sel == 2'd3 ? {16'h0, baud_div} : 32'h0;
endmodule

// File: tb/tb_uart_fifo_peripheral.sv
// tb_uart_fifo_peripheral: queue-based model of the UART bus/line behaviour checked every cycle.
module tb_uart_fifo_peripheral;
    logic clk = 1'b0, reset = 1'b1, cs = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'h8, wdata = 32'h0;
    logic [31:0] rdata;
    logic tx, rx, rx_drv = 1'b1, loop = 1'b0, chk_en = 1'b0;
    int total = 0, bad = 0;

    assign rx = loop ? tx : rx_drv;
    always #5 clk = ~clk;

    uart_fifo_peripheral dut (
        .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx(tx), .rx(rx)
    );

    logic [7:0] txq[$], rxq[$];
    bit wave[$];
    bit exp_tx = 1'b1, exp_busy = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0, full_pre;
    int m_div = 651, d;
    logic [7:0] b;
    logic [9:0] frame;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line model: each frame becomes a list of per-clock tx levels.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            txq.delete(); rxq.delete(); wave.delete();
            exp_tx = 1'b1; exp_busy = 1'b0; m_div = 651; m_ovr = 1'b0; m_ferr = 1'b0;
        end else begin
            full_pre = txq.size() == 16;
            if (wave.size() == 0 && txq.size() != 0) begin
                b = txq.pop_front();
                d = 16 * (m_div == 0 ? 1 : m_div);
                frame = {1'b1, b, 1'b0};
                for (int k = 0; k < 10; k++) repeat (d) wave.push_back(frame[k]);
            end
            if (wave.size() != 0) begin
                exp_tx = wave.pop_front();
                exp_busy = 1'b1;
            end else begin
                exp_tx = 1'b1;
                exp_busy = 1'b0;
            end
            if (cs && wr && addr[3:2] == 2'd0 && !full_pre) txq.push_back(wdata[7:0]);
            if (cs && wr && addr[3:2] == 2'd2) begin
                if (wdata[4]) m_ovr = 1'b0;
                if (wdata[6]) m_ferr = 1'b0;
            end
            if (cs && wr && addr[3:2] == 2'd3) m_div = int'(wdata[15:0]);
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (chk_en) begin
            chk("tx_line", tx, exp_tx);
            if (!cs) begin
                chk("tx_busy", rdata[5], exp_busy);
                chk("tx_empty", rdata[2], txq.size() == 0);
                chk("tx_full", rdata[3], txq.size() == 16);
            end
        end
    end

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] dv);
        cs = 1'b1; wr = 1'b1; addr = {28'h0, a, 2'b00}; wdata = dv;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; addr = 32'h8;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] e, input string nm);
        cs = 1'b1; wr = 1'b0; addr = {28'h0, a, 2'b00};
        #2;
        chk(nm, rdata, e);
        @(negedge clk);
        cs = 1'b0; addr = 32'h8;
    endtask

    task automatic rd_rx(input string nm);
        logic [31:0] e;
        e = 32'h0;
        if (rxq.size() != 0) e = {24'h0, rxq.pop_front()};
        bus_rd(2'd1, e, nm);
    endtask

    task automatic wait_tx_idle();
        int i;
        i = 0;
        while ((exp_busy || txq.size() != 0) && i < 6000) begin
            @(negedge clk);
            i++;
        end
        chk("tx_idle_in_time", i < 6000, 1);
        @(negedge clk);
    endtask

    // Drives one frame at 16 clocks per bit (BAUDDIV=1).
    task automatic inject(input logic [7:0] v, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, v, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (6) @(negedge clk);
        if (!stop_bit) m_ferr = 1'b1;
        else if (rxq.size() < 16) rxq.push_back(v);
        else m_ovr = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [9:0] pat;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("reset_tx", tx, 1);
        bus_rd(2'd2, 32'h04, "status_reset");
        bus_rd(2'd3, 32'd651, "div_reset");
        bus_rd(2'd1, 32'h0, "rxdata_empty");
        bus_rd(2'd0, 32'h0, "txdata_reads0");

        bus_wr(2'd3, 32'd1);
        bus_wr(2'd0, 32'h55);
        pat = 10'b1010101010;
        repeat (9) @(negedge clk);
        #1;
        chk("frame55_bit0", tx, pat[0]);
        for (int k = 1; k < 10; k++) begin
            repeat (16) @(negedge clk);
            #1;
            chk("frame55_bit", tx, pat[k]);
        end
        @(negedge clk);
        bus_rd(2'd2, 32'h24, "status_busy");
        wait_tx_idle();
        bus_rd(2'd2, 32'h04, "status_after_tx");

        bus_wr(2'd0, 32'h11);
        bus_wr(2'd0, 32'h22);
        bus_wr(2'd0, 32'h33);
        bus_rd(2'd2, 32'h20, "status_b2b");
        wait_tx_idle();

        bus_wr(2'd3, 32'd2);
        bus_wr(2'd0, 32'h3C);
        wait_tx_idle();
        bus_wr(2'd3, 32'd0);
        bus_rd(2'd3, 32'd0, "div_zero_rd");
        bus_wr(2'd0, 32'hC3);
        wait_tx_idle();
        bus_wr(2'd3, 32'h1234_0001);
        bus_rd(2'd3, 32'd1, "div_upper_zero");

        for (int i = 0; i < 18; i++) bus_wr(2'd0, 32'h80 + i);
        bus_rd(2'd2, 32'h28, "status_tx_full");
        wait_tx_idle();

        bus_wr(2'd0, 32'hF0);
        repeat (40) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("tx_after_reset", tx, 1);
        @(negedge clk);
        bus_rd(2'd3, 32'd651, "div_after_reset");
        bus_rd(2'd2, 32'h04, "status_after_reset");
        bus_wr(2'd3, 32'd1);

        loop = 1'b1;
        bus_wr(2'd0, 32'hA5);
        wait_tx_idle();
        repeat (10) @(negedge clk);
        rxq.push_back(8'hA5);
        bus_rd(2'd2, 32'h05, "loop_status");
        rd_rx("loop_rx");
        bus_rd(2'd2, 32'h04, "loop_status_after");
        loop = 1'b0;

        for (int i = 0; i < 17; i++) inject(8'h30 + 8'(i), 1'b1);
        bus_rd(2'd2, 32'h17, "status_overrun");
        for (int i = 0; i < 16; i++) rd_rx("rx_fifo_data");
        rd_rx("rx_after_drain");
        bus_rd(2'd2, 32'h14, "status_drained");
        bus_wr(2'd2, 32'h10);
        bus_rd(2'd2, 32'h04, "overrun_cleared");

        inject(8'h5A, 1'b0);
        bus_rd(2'd2, 32'h44, "status_frame_err");
        rd_rx("frame_err_nopush");
        bus_wr(2'd2, 32'h80);
        bus_rd(2'd2, 32'h44, "ferr_kept");
        bus_wr(2'd2, 32'h40);
        bus_rd(2'd2, 32'h04, "ferr_cleared");

        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (30) @(negedge clk);
        bus_rd(2'd2, 32'h04, "glitch_status");
        inject(8'h96, 1'b1);
        rd_rx("post_glitch_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
